// File: rtl/pfb_filter.sv
// Polyphase FIR stage: per-channel sample history, one filtered complex output per input.
// Optional: PFB_FILTER_OVERFLOW_CHECK_EN enables the Error_input_overflow pulse.
module pfb_filter #(
   parameter int NUM_CHANNELS        = 32,
   parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
   parameter int INPUT_DATA_WIDTH    = 12,
   parameter int NUM_COEFS           = 384,
   parameter int OUTPUT_DATA_WIDTH   = INPUT_DATA_WIDTH + $clog2(NUM_COEFS / NUM_CHANNELS),
   parameter int TAG_WIDTH           = 8,
   parameter int COEF_WIDTH          = 18,
   parameter logic signed [COEF_WIDTH-1:0] COEF_DATA [NUM_COEFS] = '{default: '0},
   parameter int ANALYSIS_MODE       = 1
) (
   input  logic                                Clk,
   input  logic                                Rst,
   input  logic                                Input_valid,
   input  logic [CHANNEL_INDEX_WIDTH-1:0]      Input_index,
   input  logic                                Input_last,
   input  logic [TAG_WIDTH-1:0]                Input_tag,
   input  logic signed [INPUT_DATA_WIDTH-1:0]  Input_i,
   input  logic signed [INPUT_DATA_WIDTH-1:0]  Input_q,
   output logic                                Output_valid,
   output logic [CHANNEL_INDEX_WIDTH-1:0]      Output_index,
   output logic                                Output_last,
   output logic [TAG_WIDTH-1:0]                Output_tag,
   output logic signed [OUTPUT_DATA_WIDTH-1:0] Output_i,
   output logic signed [OUTPUT_DATA_WIDTH-1:0] Output_q,
   output logic                                Error_input_overflow
);

   localparam int M   = NUM_COEFS / NUM_CHANNELS;
   localparam int S   = (ANALYSIS_MODE != 0) ? 2 : 1;
   localparam int D   = S * M;
   localparam int LOG = $clog2(M);
   localparam int P   = 1 << LOG;
   localparam int LAT = 4 + LOG;
   localparam int PW  = INPUT_DATA_WIDTH + COEF_WIDTH;
   localparam int CAW = $clog2(NUM_COEFS);
   localparam int IW  = INPUT_DATA_WIDTH;
   localparam int OW  = OUTPUT_DATA_WIDTH;

   logic                           accept;
   logic [LAT-2:0]                 vld_d;
   logic [CHANNEL_INDEX_WIDTH-1:0] idx_d  [LAT-1];
   logic                           last_d [LAT-1];
   logic [TAG_WIDTH-1:0]           tag_d  [LAT-1];

   logic signed [IW-1:0]         hist_i [NUM_CHANNELS][D];
   logic signed [IW-1:0]         hist_q [NUM_CHANNELS][D];
   logic signed [IW-1:0]         tap_i  [M];
   logic signed [IW-1:0]         tap_q  [M];
   logic signed [COEF_WIDTH-1:0] coef_r [M];
   logic signed [PW-1:0]         prod_i [M];
   logic signed [PW-1:0]         prod_q [M];
   logic signed [OW-1:0]         tree_i [LOG+1][P];
   logic signed [OW-1:0]         tree_q [LOG+1][P];

   // vld_d[0] marks an accepted input last cycle, which blocks the next one
   assign accept = Rst && Input_valid && !vld_d[0];

   always_ff @(posedge Clk) begin
      if (!Rst) vld_d <= '0;
      else      vld_d <= {vld_d[LAT-3:0], accept};
      idx_d[0]  <= Input_index;
      last_d[0] <= Input_last;
      tag_d[0]  <= Input_tag;
      for (int unsigned k = 1; k < LAT - 1; k++) begin
         idx_d[k]  <= idx_d[k-1];
         last_d[k] <= last_d[k-1];
         tag_d[k]  <= tag_d[k-1];
      end
   end

   // History is never reset; it is a true shift so tap S*i is simply entry S*i
   always_ff @(posedge Clk) begin
      if (accept) begin
         for (int unsigned k = D - 1; k > 0; k--) begin
            hist_i[Input_index][k] <= hist_i[Input_index][k-1];
            hist_q[Input_index][k] <= hist_q[Input_index][k-1];
         end
         hist_i[Input_index][0] <= Input_i;
         hist_q[Input_index][0] <= Input_q;
      end
   end

   always_ff @(posedge Clk) begin
      for (int unsigned i = 0; i < M; i++) begin
         tap_i[i]  <= hist_i[idx_d[0]][S*i];
         tap_q[i]  <= hist_q[idx_d[0]][S*i];
         coef_r[i] <= COEF_DATA[CAW'(NUM_CHANNELS*i) + CAW'(idx_d[0])];
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < M; i++) begin
         prod_i[i] = PW'(tap_i[i]) * PW'(coef_r[i]);
         prod_q[i] = PW'(tap_q[i]) * PW'(coef_r[i]);
      end
   end

   always_ff @(posedge Clk) begin
      for (int unsigned j = 0; j < P; j++) begin
         if (j < M) begin
            tree_i[0][j] <= OW'($signed(prod_i[j][PW-1:COEF_WIDTH-1]));
            tree_q[0][j] <= OW'($signed(prod_q[j][PW-1:COEF_WIDTH-1]));
         end else begin
            tree_i[0][j] <= '0;
            tree_q[0][j] <= '0;
         end
      end
      for (int unsigned l = 0; l < LOG; l++) begin
         for (int unsigned j = 0; j < (P >> (l + 1)); j++) begin
            tree_i[l+1][j] <= tree_i[l][2*j] + tree_i[l][2*j+1];
            tree_q[l+1][j] <= tree_q[l][2*j] + tree_q[l][2*j+1];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         Output_valid <= 1'b0;
         Output_index <= '0;
         Output_last  <= 1'b0;
         Output_tag   <= '0;
         Output_i     <= '0;
         Output_q     <= '0;
      end else begin
         Output_valid <= vld_d[LAT-2];
         if (vld_d[LAT-2]) begin
            Output_index <= idx_d[LAT-2];
            Output_last  <= last_d[LAT-2];
            Output_tag   <= tag_d[LAT-2];
            Output_i     <= tree_i[LOG][0];
            Output_q     <= tree_q[LOG][0];
         end
      end
   end

`ifdef PFB_FILTER_OVERFLOW_CHECK_EN
   always_ff @(posedge Clk) begin
      if (!Rst) Error_input_overflow <= 1'b0;
      else      Error_input_overflow <= Input_valid && vld_d[0];
   end
`else
   assign Error_input_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pfb_filter.sv
// Randomised bench for pfb_filter against a per-channel history/dot-product reference model.
module tb_pfb_filter;
   localparam int NC = 32, IW = 12, OW = 16, TW = 8, CW = 18, NCOEF = 384;
   localparam int M = 12, D = 24, LAT = 8;

   typedef logic signed [CW-1:0] coef_arr_t [NCOEF];

   function automatic coef_arr_t gen_coefs();
      coef_arr_t c;
      int unsigned s = 32'h1234_5678;
      for (int k = 0; k < NCOEF; k++) begin
         s = s * 1664525 + 1013904223;
         c[k] = s[31:14];
      end
      c[0]   = 18'sd0;
      c[32]  = 18'sd227;
      c[192] = 18'sd131069;
      return c;
   endfunction

   localparam coef_arr_t COEFS = gen_coefs();

   logic                 Clk, Rst;
   logic                 Input_valid, Input_last;
   logic [4:0]           Input_index;
   logic [TW-1:0]        Input_tag;
   logic signed [IW-1:0] Input_i, Input_q;
   logic                 Output_valid, Output_last, Error_input_overflow;
   logic [4:0]           Output_index;
   logic [TW-1:0]        Output_tag;
   logic signed [OW-1:0] Output_i, Output_q;

   pfb_filter #(
      .NUM_CHANNELS(NC), .INPUT_DATA_WIDTH(IW), .TAG_WIDTH(TW), .COEF_WIDTH(CW),
      .NUM_COEFS(NCOEF), .COEF_DATA(COEFS), .ANALYSIS_MODE(1)
   ) dut (
      .Clk(Clk), .Rst(Rst),
      .Input_valid(Input_valid), .Input_index(Input_index), .Input_last(Input_last),
      .Input_tag(Input_tag), .Input_i(Input_i), .Input_q(Input_q),
      .Output_valid(Output_valid), .Output_index(Output_index), .Output_last(Output_last),
      .Output_tag(Output_tag), .Output_i(Output_i), .Output_q(Output_q),
      .Error_input_overflow(Error_input_overflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic [4:0]    idx;
      logic          last;
      logic [TW-1:0] tag;
      logic [OW-1:0] i;
      logic [OW-1:0] q;
   } exp_t;

   exp_t expq[$];
   exp_t e;
   int   hist_i [NC][D];
   int   hist_q [NC][D];
   int   ch0_log[$];
   int   vectors, miscompares, err_pulses, out_count;
   bit   check_en, log_en;

   // y = sum over taps of floor(coef * sample / 2^17), wrapped to OW bits
   function automatic logic [OW-1:0] fir(int c, bit use_q);
      longint acc = 0;
      longint p;
      for (int i = 0; i < M; i++) begin
         p = longint'(COEFS[NC*i + c]) * longint'(use_q ? hist_q[c][2*i] : hist_i[c][2*i]);
         acc += p >>> (CW - 1);
      end
      return acc[OW-1:0];
   endfunction

   task automatic model_accept(input int idx, input bit last, input int tag, input int xi, input int xq);
      exp_t x;
      for (int k = D - 1; k > 0; k--) begin
         hist_i[idx][k] = hist_i[idx][k-1];
         hist_q[idx][k] = hist_q[idx][k-1];
      end
      hist_i[idx][0] = xi;
      hist_q[idx][0] = xq;
      x.idx = idx[4:0]; x.last = last; x.tag = tag[TW-1:0];
      x.i = fir(idx, 1'b0); x.q = fir(idx, 1'b1);
      expq.push_back(x);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge Clk); #1; end
   endtask

   task automatic send(input int idx, input bit last, input int tag, input int xi, input int xq);
      Input_valid = 1'b1; Input_index = idx[4:0]; Input_last = last;
      Input_tag = tag[TW-1:0]; Input_i = xi[IW-1:0]; Input_q = xq[IW-1:0];
      model_accept(idx, last, tag, xi, xq);
      idle(1);
      Input_valid = 1'b0;
   endtask

   function automatic int rnd_sample();
      int r = int'($urandom_range(0, 4095));
      return (r >= 2048) ? r - 4096 : r;
   endfunction

   always @(negedge Clk) begin
      if (Output_valid) begin
         out_count++;
         if (log_en && Output_index == 5'd0) ch0_log.push_back(int'(Output_i));
         if (expq.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_output idx=%0d i=%0d q=%0d, no output was required", Output_index, Output_i, Output_q);
         end else begin
            e = expq.pop_front();
            if (check_en) begin
               vectors++;
               if ({Output_index, Output_last, Output_tag, Output_i, Output_q} !== {e.idx, e.last, e.tag, e.i, e.q}) begin
                  miscompares++;
                  $display("FAIL output got idx=%0d last=%0d tag=%0h i=%0d q=%0d, need idx=%0d last=%0d tag=%0h i=%0d q=%0d",
                           Output_index, Output_last, Output_tag, Output_i, Output_q,
                           e.idx, e.last, e.tag, $signed(e.i), $signed(e.q));
               end
            end
         end
      end
      if (Error_input_overflow) err_pulses++;
   end

   task automatic check_outputs_zero(input string name);
      @(negedge Clk);
      vectors++;
      if ({Output_valid, Output_index, Output_last, Output_tag, Output_i, Output_q, Error_input_overflow} !== '0) begin
         miscompares++;
         $display("FAIL %s got valid=%0d idx=%0d last=%0d tag=%0h i=%0d q=%0d err=%0d, need all 0", name,
                  Output_valid, Output_index, Output_last, Output_tag, Output_i, Output_q, Error_input_overflow);
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      for (int n = 0; n < 10; n++) begin
         Input_valid = n[0] | n[2]; Input_index = 5'(n); Input_i = 12'(rnd_sample());
         idle(1);
      end
      Input_valid = 1'b0;
      check_outputs_zero("reset_state");
      vectors++;
      if (err_pulses !== 0) begin
         miscompares++;
         $display("FAIL reset_overflow got %0d pulses, need 0", err_pulses);
      end
      Rst = 1'b1;
      idle(2);
   endtask

   task automatic clear_history();
      for (int n = 0; n < 1024; n++) begin
         send(31 - (n % 32), (n % 32) == 31, n & 255, 0, 0);
         idle(1);
      end
      idle(LAT + 4);
   endtask

   task automatic test_impulse(input int amp, input int exp1, input int exp3, input int exp13);
      clear_history();
      check_en = 1'b1;
      ch0_log.delete();
      log_en = 1'b1;
      send(0, 1'b1, 8'h11, amp, 0);
      idle(1);
      for (int f = 0; f < 12; f++)
         for (int c = 31; c >= 0; c--) begin
            send(c, c == 0, f, 0, 0);
            idle(1);
         end
      idle(LAT + 4);
      log_en = 1'b0;
      vectors++;
      if (ch0_log.size() != 13) begin
         miscompares++;
         $display("FAIL impulse_count amp=%0d got %0d ch0 outputs, need 13", amp, ch0_log.size());
      end else begin
         vectors += 4;
         if (ch0_log[0] != exp1)  begin miscompares++; $display("FAIL impulse_1st amp=%0d got %0d need %0d", amp, ch0_log[0], exp1); end
         if (ch0_log[1] != 0)     begin miscompares++; $display("FAIL impulse_2nd amp=%0d got %0d need 0", amp, ch0_log[1]); end
         if (ch0_log[2] != exp3)  begin miscompares++; $display("FAIL impulse_3rd amp=%0d got %0d need %0d", amp, ch0_log[2], exp3); end
         if (ch0_log[12] != exp13) begin miscompares++; $display("FAIL impulse_13th amp=%0d got %0d need %0d", amp, ch0_log[12], exp13); end
      end
   endtask

   task automatic test_latency();
      int lat;
      bit found;
      idle(20);
      Input_valid = 1'b1; Input_index = 5'd5; Input_last = 1'b0; Input_tag = 8'hA5;
      Input_i = 12'sd100; Input_q = -12'sd77;
      model_accept(5, 1'b0, 8'hA5, 100, -77);
      idle(1);
      Input_valid = 1'b0;
      lat = 1; found = 1'b0;
      while (!found && lat < 20) begin
         @(negedge Clk);
         if (Output_valid) found = 1'b1;
         else begin @(posedge Clk); #1; lat++; end
      end
      vectors++;
      if (!found || lat != LAT || Output_index !== 5'd5 || Output_tag !== 8'hA5) begin
         miscompares++;
         $display("FAIL latency got found=%0d lat=%0d idx=%0d tag=%0h, need lat=%0d idx=5 tag=a5",
                  found, lat, Output_index, Output_tag, LAT);
      end
      @(posedge Clk); #1;
      idle(10);
   endtask

   task automatic test_overflow();
      int e0, o0, need_err;
      idle(20);
      e0 = err_pulses; o0 = out_count;
      Input_valid = 1'b1; Input_index = 5'd9; Input_last = 1'b0; Input_tag = 8'h3C;
      Input_i = 12'sd500; Input_q = 12'sd12;
      model_accept(9, 1'b0, 8'h3C, 500, 12);
      idle(1);
      Input_index = 5'd9; Input_tag = 8'h3D; Input_i = -12'sd900; Input_q = 12'sd1;
      idle(1);
      Input_valid = 1'b0;
      idle(20);
`ifdef PFB_FILTER_OVERFLOW_CHECK_EN
      need_err = 1;
`else
      need_err = 0;
`endif
      vectors += 2;
      if (out_count - o0 != 1) begin
         miscompares++;
         $display("FAIL overflow_outputs got %0d, need 1", out_count - o0);
      end
      if (err_pulses - e0 != need_err) begin
         miscompares++;
         $display("FAIL overflow_pulse got %0d cycles, need %0d", err_pulses - e0, need_err);
      end
   endtask

   task automatic stream(input int n, input int max_gap);
      int c;
      for (int k = 0; k < n; k++) begin
         c = int'($urandom_range(0, NC - 1));
         send(c, c == 0, int'($urandom_range(0, 255)), rnd_sample(), rnd_sample());
         idle(1 + int'($urandom_range(0, max_gap)));
      end
      idle(LAT + 4);
   endtask

   task automatic test_random();
      int e0 = err_pulses;
      stream(10000, 5);
      vectors += 2;
      if (err_pulses != e0) begin
         miscompares++;
         $display("FAIL random_overflow got %0d pulses, need 0", err_pulses - e0);
      end
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL random_drain got %0d pending, need 0", expq.size());
      end
   endtask

   task automatic test_reset_mid();
      stream(20, 3);
      send(3, 1'b0, 8'h01, rnd_sample(), rnd_sample());
      idle(1);
      send(4, 1'b0, 8'h02, rnd_sample(), rnd_sample());
      idle(1);
      Rst = 1'b0;
      vectors++;
      if (expq.size() != 2) begin
         miscompares++;
         $display("FAIL reset_mid_pending got %0d outputs already out of 2 pending", 2 - expq.size());
      end
      expq.delete();
      idle(498);
      check_outputs_zero("reset_mid_outputs");
      Rst = 1'b1;
      idle(2);
      stream(200, 2);
      vectors++;
      if (expq.size() != 0) begin
         miscompares++;
         $display("FAIL reset_resume got %0d pending, need 0", expq.size());
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; err_pulses = 0; out_count = 0;
      check_en = 1'b0; log_en = 1'b0;
      for (int c = 0; c < NC; c++)
         for (int k = 0; k < D; k++) begin hist_i[c][k] = 0; hist_q[c][k] = 0; end
      Rst = 1'b0; Input_valid = 1'b0; Input_index = '0; Input_last = 1'b0;
      Input_tag = '0; Input_i = '0; Input_q = '0;
      @(posedge Clk); #1;
      test_reset();
      test_impulse(2047, 0, 3, 2046);
      test_impulse(-2048, 0, -4, -2048);
      test_latency();
      test_overflow();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
